// File: rtl/logic_unit_cache_if.sv
// Handshake and cache-read bundle for logic_unit_cache.
//   master: producer/consumer side (drives operands, out_ready, rd_addr)
//   slave : the logic unit (drives in_ready, result, tag, rd_data, count)
interface logic_unit_cache_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op;
  logic [WIDTH-1:0]  in_1;
  logic [WIDTH-1:0]  in_2;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out;
  logic [ADDR_W-1:0] out_tag;
  logic [ADDR_W-1:0] rd_addr;
  logic [WIDTH-1:0]  rd_data;
  logic [ADDR_W:0]   count;

  modport master (
    output in_valid, op, in_1, in_2, out_ready, rd_addr,
    input  in_ready, out_valid, out, out_tag, rd_data, count
  );

  modport slave (
    input  in_valid, op, in_1, in_2, out_ready, rd_addr,
    output in_ready, out_valid, out, out_tag, rd_data, count
  );
endinterface

// File: rtl/logic_unit_cache.sv
// Registered bitwise logic unit with valid/ready on both sides. Every accepted
// result is also written to a DEPTH-entry circular cache with a registered,
// read-before-write read port.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - logic_unit_cache_if.slave: in_valid/in_ready/op/in_1/in_2,
//          out_valid/out_ready/out/out_tag, rd_addr/rd_data, count
module logic_unit_cache #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic               clk,
  input logic               rst,
  logic_unit_cache_if.slave bus
);
  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NAND = 3'b011;
  localparam logic [2:0] OP_NOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_NOT  = 3'b110;

  logic [WIDTH-1:0]  out_q, out_d;
  logic [ADDR_W-1:0] out_tag_q, out_tag_d;
  logic              out_valid_q, out_valid_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0]  cache_q [DEPTH];
  logic [WIDTH-1:0]  cache_d [DEPTH];

  logic              in_ready_c;
  logic              accept_c;
  logic [WIDTH-1:0]  result_c;

  // Bitwise function of the current operands.
  always_comb begin
    result_c = bus.in_1;
    case (bus.op)
      OP_AND:  result_c = bus.in_1 & bus.in_2;
      OP_OR:   result_c = bus.in_1 | bus.in_2;
      OP_XOR:  result_c = bus.in_1 ^ bus.in_2;
      OP_NAND: result_c = ~(bus.in_1 & bus.in_2);
      OP_NOR:  result_c = ~(bus.in_1 | bus.in_2);
      OP_XNOR: result_c = ~(bus.in_1 ^ bus.in_2);
      OP_NOT:  result_c = ~bus.in_1;
      default: result_c = bus.in_1;
    endcase
  end

  // Handshake, result register, cache write and read next-state.
  always_comb begin
    in_ready_c  = !out_valid_q || bus.out_ready;
    accept_c    = bus.in_valid && in_ready_c;

    out_d       = out_q;
    out_tag_d   = out_tag_q;
    out_valid_d = out_valid_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    cache_d     = cache_q;
    // Read from the pre-write array: same-slot read returns the old value.
    rd_data_d   = cache_q[bus.rd_addr];

    if (accept_c) begin
      out_d             = result_c;
      out_tag_d         = wr_ptr_q;
      out_valid_d       = 1'b1;
      cache_d[wr_ptr_q] = result_c;
      // DEPTH is a power of two, so the natural wrap of wr_ptr is mod DEPTH.
      wr_ptr_d          = wr_ptr_q + ADDR_W'(1);
      if (count_q != CNT_W'(DEPTH)) begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q       <= '0;
      out_tag_q   <= '0;
      out_valid_q <= 1'b0;
      rd_data_q   <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        cache_q[i] <= '0;
      end
    end else begin
      out_q       <= out_d;
      out_tag_q   <= out_tag_d;
      out_valid_q <= out_valid_d;
      rd_data_q   <= rd_data_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      cache_q     <= cache_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out       = out_q;
  assign bus.out_tag   = out_tag_q;
  assign bus.out_valid = out_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.count     = count_q;
endmodule

// File: tb/tb_logic_unit_cache.sv
// Scoreboard bench for logic_unit_cache: the driver pushes expected results
// and read data from a behavioural model; a monitor pops and compares.
module tb_logic_unit_cache;
  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  typedef struct packed {
    logic [W-1:0] res;
    logic [1:0]   tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  logic_unit_cache_if #(.WIDTH(W), .DEPTH(D)) bus ();

  logic_unit_cache #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t         exp_q[$];
  logic [W-1:0] rd_q[$];
  logic [W-1:0] mdl_cache [D];
  int           mdl_wp;
  int           mdl_count;
  bit           mdl_ov;
  int           mdl_count_now;
  bit           mdl_ov_now;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] lu_ref(input logic [2:0] o, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (o)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a ^ b;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return ~(a ^ b);
      3'd6:    return ~a;
      default: return a;
    endcase
  endfunction

  // One clock of stimulus; the model advances to the state after the next edge.
  task automatic drive(input bit r, input bit iv, input logic [2:0] o, input logic [W-1:0] a,
                       input logic [W-1:0] b, input bit ordy, input logic [1:0] ra);
    bit           acc;
    logic [W-1:0] res;
    @(negedge clk);
    rst           = r;
    bus.in_valid  = iv;
    bus.op        = o;
    bus.in_1      = a;
    bus.in_2      = b;
    bus.out_ready = ordy;
    bus.rd_addr   = ra;
    #1;
    if (r) begin
      exp_q.delete();
      rd_q.delete();
      rd_q.push_back('0);
      for (int i = 0; i < int'(D); i++) mdl_cache[i] = '0;
      mdl_wp    = 0;
      mdl_count = 0;
      mdl_ov    = 1'b0;
    end else begin
      mdl_count_now = mdl_count;
      mdl_ov_now    = mdl_ov;
      rd_q.push_back(mdl_cache[ra]);
      acc = iv && (!mdl_ov || ordy);
      if (acc) begin
        res = lu_ref(o, a, b);
        exp_q.push_back('{res: res, tag: 2'(mdl_wp)});
        mdl_cache[mdl_wp] = res;
        mdl_wp = (mdl_wp + 1) % int'(D);
        if (mdl_count < int'(D)) mdl_count++;
      end
      mdl_ov = acc || (mdl_ov && !ordy);
    end
  endtask

  task automatic idle(input logic [1:0] ra);
    drive(1'b0, 1'b0, 3'd0, '0, '0, 1'b1, ra);
  endtask

  // Monitor: compares registered outputs against the scoreboard each cycle.
  initial begin
    exp_t e;
    logic [W-1:0] r;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b0) begin
        chk("count", 32'(bus.count), 32'(mdl_count_now));
        chk("out_valid", 32'(bus.out_valid), 32'(mdl_ov_now));
        chk("in_ready", 32'(bus.in_ready), 32'(!mdl_ov_now || bus.out_ready));
        if (bus.out_valid === 1'b1) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'(bus.out), 32'hDEAD_BEEF);
          end else begin
            e = exp_q[0];
            chk("out", 32'(bus.out), 32'(e.res));
            chk("out_tag", 32'(bus.out_tag), 32'(e.tag));
            if (bus.out_ready) void'(exp_q.pop_front());
          end
        end
        if (rd_q.size() > 1) begin
          r = rd_q.pop_front();
          chk("rd_data", 32'(bus.rd_data), 32'(r));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.in_1      = '0;
    bus.in_2      = '0;
    bus.out_ready = 1'b1;
    bus.rd_addr   = '0;

    // Reset with in_valid high, then read every slot back.
    drive(1'b1, 1'b1, 3'd2, 8'hFF, 8'h0F, 1'b1, 2'd0);
    drive(1'b1, 1'b1, 3'd2, 8'hFF, 8'h0F, 1'b1, 2'd0);
    idle(2'd0);
    #1;
    chk("reset_out", 32'(bus.out), 32'h0);
    chk("reset_out_tag", 32'(bus.out_tag), 32'h0);
    for (int i = 1; i < 4; i++) idle(2'(i));
    idle(2'd0);

    // XOR basic.
    drive(1'b0, 1'b1, 3'd2, 8'h00, 8'h55, 1'b1, 2'd0);
    drive(1'b0, 1'b1, 3'd2, 8'h00, 8'hAA, 1'b1, 2'd1);
    idle(2'd1);

    // Op sweep.
    for (int o = 0; o < 8; o++) drive(1'b0, 1'b1, 3'(o), 8'hF0, 8'h3C, 1'b1, 2'(o));
    idle(2'd0);

    // Backpressure then simultaneous drain and accept.
    drive(1'b0, 1'b1, 3'd2, 8'h00, 8'h11, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 3'd2, 8'h00, 8'h22, 1'b0, 2'd0);
    drive(1'b0, 1'b1, 3'd2, 8'h00, 8'h22, 1'b1, 2'd0);
    idle(2'd0);

    // Wrap-around and readback; 5th write reads its own slot (old value).
    drive(1'b1, 1'b0, 3'd0, '0, '0, 1'b1, 2'd0);
    for (int i = 1; i <= 5; i++) begin
      v = 8'(i);
      drive(1'b0, 1'b1, 3'd2, 8'h00, v, 1'b1, 2'd0);
    end
    for (int i = 0; i < 4; i++) idle(2'(i));
    idle(2'd0);

    // Reset mid-stream while stalled with in_valid high.
    drive(1'b0, 1'b1, 3'd1, 8'h0F, 8'hF0, 1'b0, 2'd0);
    drive(1'b0, 1'b1, 3'd0, 8'h0F, 8'hF0, 1'b0, 2'd0);
    drive(1'b1, 1'b1, 3'd0, 8'h0F, 8'hF0, 1'b0, 2'd0);
    for (int i = 0; i < 4; i++) idle(2'(i));
    idle(2'd0);

    // Randomised traffic with occasional reset.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 127) == 0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            8'($urandom), 8'($urandom), $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)));
    end
    idle(2'd0);
    idle(2'd1);
    @(negedge clk);
    #3;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/logic_unit_cache.md
Name: logic_unit_cache

Overview:
Parametrised, registered bitwise logic unit with op select and valid/ready handshake on both sides. Every accepted result is also written into a DEPTH-entry circular result cache, readable through an independent read port. Sits downstream of operand sources in the LU datapath and replaces single-function combinational gates (XOR, AND, ...) with one shared sequential unit.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
DEPTH, 4, result cache entries; power of 2, >=2
ADDR_W, $clog2(DEPTH), derived cache address width; not overridden

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  operands and op valid
in_ready  output  1  unit can accept this cycle
op  input  3  operation select
in_1  input  WIDTH  operand 1
in_2  input  WIDTH  operand 2
out_valid  output  1  result register holds a result
out_ready  input  1  consumer accepts result
out  output  WIDTH  registered result
out_tag  output  ADDR_W  cache slot that result was written to
rd_addr  input  ADDR_W  cache read address
rd_data  output  WIDTH  cache read data, 1-cycle latency
count  output  ADDR_W+1  valid cache entries, saturates at DEPTH

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, out=0, out_tag=0, rd_data=0, count=0, write pointer=0; all cache entries cleared to 0. Reset overrides any simultaneous accept/read.
- Ops: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT in_1 (in_2 ignored), 111 pass in_1. All bitwise, full WIDTH, no carries.
- in_ready = !out_valid || out_ready (combinational; one-entry pipeline, full throughput).
- Accept = in_valid && in_ready. On accept at posedge N: out <= f(op,in_1,in_2), out_tag <= wr_ptr, out_valid <= 1, cache[wr_ptr] <= same result, wr_ptr <= wr_ptr+1 mod DEPTH, count <= min(count+1, DEPTH). Result visible on out from cycle N+1 (latency 1).
- Output drain: out_valid && out_ready && !accept -> out_valid <= 0; out/out_tag hold last values.
- Stall: out_valid && !out_ready -> in_ready=0; out, out_tag, out_valid held stable; no cache write.
- Simultaneous drain and accept: out_valid stays 1, new result loaded, no bubble.
- in_valid=0: no state change except drain.
- Wrap-around: after DEPTH accepts wr_ptr returns to 0 and oldest entry is overwritten; count stays DEPTH.
- Read port: rd_data <= cache[rd_addr] every cycle (registered, 1 cycle). Read of the slot being written in the same cycle returns the OLD contents (read-before-write); new value visible on the following read.
- Inputs change while in_ready=0: ignored; producer must hold in_valid until accepted.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in_valid=1 -> out_valid=0, out=0, count=0, in_ready=1 after release; rd_data=0 for every address.
- XOR basic (WIDTH=8): op=010, in_1=0x00, in_2=0x55, then in_2=0xAA, out_ready=1 -> out=0x55 tag 0, then out=0xAA tag 1, one result per cycle, count=2.
- Op sweep: in_1=0xF0, in_2=0x3C over op 000..111 -> 0x30,0xFC,0xCC,0xCF,0x03,0x33,0x0F,0xF0.
- Backpressure: hold out_ready=0 after first accept -> in_ready=0, out frozen for 5 cycles, second operand not taken; raise out_ready with in_valid=1 -> drain and accept in same cycle, no bubble.
- Wrap/readback (DEPTH=4): accept 5 XOR results 0x01..0x05 (in_1=0, in_2=value) -> count saturates at 4, tags 0,1,2,3,0; rd_addr=0 returns 0x05, rd_addr=1..3 return 0x02..0x04 one cycle later; read of slot being written returns old value.
- Reset mid-stream: assert rst while out_valid=1, out_ready=0 and in_valid=1 -> next cycle out_valid=0, count=0, all cache reads 0.
